// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic job sequencer.
// Holds the FSM encoding, phase lengths and operand index helpers.
package systolic_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    FLUSH,
    DRAIN,
    DONE
  } state_t;

  localparam int FEED_LEN  = 13;
  localparam int FLUSH_LEN = 2;
  localparam int DRAIN_LEN = 2;

  function automatic int i_idx(input int r, input int c);
    return 4 * r + c;
  endfunction

  function automatic int f_idx(input int r, input int c);
    return 3 * r + c;
  endfunction

endpackage

// File: rtl/systolic_operand_rom.sv
// Skewed operand stream tables for the 2x2 array.
// Picks a0/a1/b0/b1 from the latched job by feed phase k.
module systolic_operand_rom
  import systolic_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic           feed,
  input  logic [3:0]     k,
  input  logic [16*DW-1:0] i_mat,
  input  logic [9*DW-1:0]  f_mat,
  output logic [DW-1:0]  a0,
  output logic [DW-1:0]  a1,
  output logic [DW-1:0]  b0,
  output logic [DW-1:0]  b1
);

  logic [DW-1:0] i [4][4];
  logic [DW-1:0] f [3][3];

  for (genvar r = 0; r < 4; r++) begin : g_ir
    for (genvar c = 0; c < 4; c++) begin : g_ic
      assign i[r][c] = i_mat[DW*i_idx(r, c) +: DW];
    end
  end

  for (genvar r = 0; r < 3; r++) begin : g_fr
    for (genvar c = 0; c < 3; c++) begin : g_fc
      assign f[r][c] = f_mat[DW*f_idx(r, c) +: DW];
    end
  end

  // b1 trails b0 by four cycles so PE1 meets the shifted window
  always_comb begin
    a0 = '0;
    a1 = '0;
    b0 = '0;
    b1 = '0;
    if (feed) begin
      unique case (k)
        4'd0: begin
          a0 = i[0][0]; b0 = f[2][2];
        end
        4'd1: begin
          a0 = i[1][0]; a1 = i[1][0];
          b0 = f[1][2];
        end
        4'd2: begin
          a0 = i[2][0]; a1 = i[2][0];
          b0 = f[0][2];
        end
        4'd3: begin
          a0 = i[0][1]; a1 = i[3][0];
          b0 = f[2][1];
        end
        4'd4: begin
          a0 = i[1][1]; a1 = i[1][1];
          b0 = f[1][1]; b1 = f[2][2];
        end
        4'd5: begin
          a0 = i[2][1]; a1 = i[2][1];
          b0 = f[0][1]; b1 = f[1][2];
        end
        4'd6: begin
          a0 = i[0][2]; a1 = i[3][1];
          b0 = f[2][0]; b1 = f[0][2];
        end
        4'd7: begin
          a0 = i[1][2]; a1 = i[1][2];
          b0 = f[1][0]; b1 = f[2][1];
        end
        4'd8: begin
          a0 = i[2][2]; a1 = i[2][2];
          b0 = f[0][0]; b1 = f[1][1];
        end
        4'd9: begin
          a0 = i[0][3]; a1 = i[3][2];
          b1 = f[0][1];
        end
        4'd10: begin
          a0 = i[1][3]; a1 = i[1][3];
          b1 = f[2][0];
        end
        4'd11: begin
          a0 = i[2][3]; a1 = i[2][3];
          b1 = f[1][0];
        end
        4'd12: begin
          a1 = i[3][3]; b1 = f[0][0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/systolic_job_sequencer.sv
// Start/done job controller for the 2x2 systolic convolution array.
// Latches a job, feeds skewed operands, flushes, drains and captures results.
module systolic_job_sequencer
  import systolic_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [16*DW-1:0] i_mat,
  input  logic [9*DW-1:0]  f_mat,
  output logic             busy,
  output logic             done,
  output logic             res_valid,
  output logic [DW-1:0]    a0,
  output logic [DW-1:0]    a1,
  output logic [DW-1:0]    b0,
  output logic [DW-1:0]    b1,
  output logic             pe_mode,
  output logic             pe_en,
  output logic             pe_clr,
  input  logic [DW-1:0]    pe_out1,
  input  logic [DW-1:0]    pe_out2,
  output logic [DW-1:0]    o00,
  output logic [DW-1:0]    o01,
  output logic [DW-1:0]    o10,
  output logic [DW-1:0]    o11
);

  state_t state, nxt;
  logic [3:0] k;
  logic [16*DW-1:0] i_lat;
  logic [9*DW-1:0]  f_lat;
  logic accept;

  assign accept = (state == IDLE) && start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt     = state;
    busy    = 1'b1;
    done    = 1'b0;
    pe_en   = 1'b0;
    pe_clr  = 1'b0;
    pe_mode = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) nxt = CLEAR;
      end
      CLEAR: begin
        pe_clr = 1'b1;
        nxt    = FEED;
      end
      FEED: begin
        pe_en = 1'b1;
        if (k == 4'(FEED_LEN - 1)) nxt = FLUSH;
      end
      FLUSH: begin
        pe_en = 1'b1;
        if (k == 4'(FLUSH_LEN - 1)) nxt = DRAIN;
      end
      DRAIN: begin
        pe_en   = 1'b1;
        pe_mode = 1'b1;
        if (k == 4'(DRAIN_LEN - 1)) nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        nxt  = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k         <= '0;
      i_lat     <= '0;
      f_lat     <= '0;
      res_valid <= 1'b0;
      o00       <= '0;
      o01       <= '0;
      o10       <= '0;
      o11       <= '0;
    end else begin
      if (nxt != state || state == IDLE) k <= '0;
      else                               k <= k + 4'd1;
      if (accept) begin
        i_lat     <= i_mat;
        f_lat     <= f_mat;
        res_valid <= 1'b0;
      end
      // bottom row drains first, then the top row shifts into it
      if (state == DRAIN && k == 4'd0) begin
        o10 <= pe_out1;
        o11 <= pe_out2;
      end
      if (state == DRAIN && k == 4'd1) begin
        o00 <= pe_out1;
        o01 <= pe_out2;
      end
      if (state == DRAIN && nxt == DONE) res_valid <= 1'b1;
    end
  end

  systolic_operand_rom #(.DW(DW)) u_rom (
    .feed  (state == FEED),
    .k     (k),
    .i_mat (i_lat),
    .f_mat (f_lat),
    .a0    (a0),
    .a1    (a1),
    .b0    (b0),
    .b1    (b1)
  );

endmodule
